// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU widths, register-0 constant and the write-back
//            request type used by the register-file write-back path.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    // One pending register-file write: destination and value
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Register 0 is hard-wired; a write to it must never reach the file
    function automatic logic is_real_dest(input logic [REG_AW-1:0] a);
        return a != ZERO_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous in-order queue of load results awaiting the
//            register-file write port. Each slot's valid bit and address are
//            exposed so the hazard logic can match pending destinations.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_req_t                       push_req,
    input  logic                          pop,
    output wb_req_t                       head,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  ent_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

    wb_req_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic w_push;
    logic w_pop;

    // Guard against overflow/underflow even if the caller misbehaves
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    // Pointer, occupancy and per-slot valid tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr          <= r_rd_ptr + PW'(1);
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + PW'(1);
                r_valid[r_wr_ptr] <= 1'b1;
            end
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

    // Payload storage; contents are meaningless unless the slot is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_req;
        end
    end

    assign ent_valid = r_valid;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_ent
            assign ent_addr[i] = r_mem[i].addr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Merges single-cycle ALU results and queued load results onto the
//            single register-file write port, one write per cycle. ALU has
//            priority, bounded by a starvation counter that forces the queued
//            load after STARVE_MAX consecutive ALU wins. Writes to register 0
//            are consumed silently. Reports pending destinations to the
//            hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_wr,
    input  logic [DATA_W-1:0] alu_wd,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_wr,
    input  logic [DATA_W-1:0] mem_wd,
    output logic [REG_AW-1:0] wr,
    output logic [DATA_W-1:0] wd,
    output logic              regwr,
    input  logic [REG_AW-1:0] rr1,
    input  logic [REG_AW-1:0] rr2,
    output logic              busy1,
    output logic              busy2
);

    localparam int             SW           = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  C_STARVE_MAX = SW'(STARVE_MAX);

    wb_req_t                      w_head;
    logic                         w_full;
    logic                         w_empty;
    logic [DEPTH-1:0]             w_ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0] w_ent_addr;

    logic w_starved;
    logic w_alu_fire;
    logic w_mem_push;
    logic w_pop;
    logic w_hit1;
    logic w_hit2;

    logic [SW-1:0]     r_starve_cnt;
    logic [REG_AW-1:0] r_wr;
    logic [DATA_W-1:0] r_wd;
    logic              r_regwr;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_mem_push),
        .push_req  ('{addr: mem_wr, data: mem_wd}),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .ent_valid (w_ent_valid),
        .ent_addr  (w_ent_addr)
    );

    // The ALU is held off for one cycle once the queued head has waited out
    // STARVE_MAX consecutive ALU grants
    assign w_starved  = ~w_empty & (r_starve_cnt == C_STARVE_MAX);
    assign alu_ready  = ~rst & ~w_starved;
    assign mem_ready  = ~rst & ~w_full;
    assign w_alu_fire = alu_valid & alu_ready;
    assign w_mem_push = mem_valid & mem_ready;
    assign w_pop      = ~rst & ~w_alu_fire & ~w_empty;

    // Count consecutive ALU wins over a waiting load; any pop or empty queue restarts it
    always_ff @(posedge clk) begin
        if (rst || w_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else if (w_alu_fire && (r_starve_cnt != C_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    // Registered write port: load the granted request, or drop the enable when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= ZERO_REG;
            r_wd    <= '0;
            r_regwr <= 1'b0;
        end else if (w_alu_fire) begin
            r_wr    <= alu_wr;
            r_wd    <= alu_wd;
            r_regwr <= is_real_dest(alu_wr);
        end else if (w_pop) begin
            r_wr    <= w_head.addr;
            r_wd    <= w_head.data;
            r_regwr <= is_real_dest(w_head.addr);
        end else begin
            r_regwr <= 1'b0;
        end
    end

    assign wr    = r_wr;
    assign wd    = r_wd;
    assign regwr = r_regwr;

    // Match each query against queued loads and the write currently on the port
    always_comb begin
        w_hit1 = r_regwr & (r_wr == rr1);
        w_hit2 = r_regwr & (r_wr == rr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i] && (w_ent_addr[i] == rr1)) begin
                w_hit1 = 1'b1;
            end
            if (w_ent_valid[i] && (w_ent_addr[i] == rr2)) begin
                w_hit2 = 1'b1;
            end
        end
    end

    assign busy1 = ~rst & is_real_dest(rr1) & w_hit1;
    assign busy2 = ~rst & is_real_dest(rr2) & w_hit2;

endmodule
`default_nettype wire
